// File: rtl/monitor_pkg.sv
// Shared types and constants for the monitor command dispatcher: state encoding,
// default command field widths and the data value returned by a timed-out read.
package monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } disp_state_t;

    localparam int AGRP_W_DEF = 7;
    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    localparam int CMD_W_DEF  = 1 + AGRP_W_DEF + ADDR_W_DEF + DATA_W_DEF;

    // Wide enough for any practical DATA_W; sliced down at the use site.
    localparam logic [63:0] TIMEOUT_DATA = '1;

    function automatic int cmd_width(input int agrp_w, input int addr_w, input int data_w);
        return 1 + agrp_w + addr_w + data_w;
    endfunction

endpackage

// File: rtl/mon_cmd_watchdog.sv
// Handshake watchdog: counts enabled cycles since the last clear and flags the
// cycle in which the TIMEOUT_CYC-th enabled cycle is reached.
module mon_cmd_watchdog
    import monitor_pkg::*;
#(
    parameter  int TIMEOUT_CYC = 1024,
    localparam int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cnt_en_i,
    input  logic clr_i,
    output logic expired_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired_o = cnt_en_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_en_i && !expired_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mon_cmd_dispatcher.sv
// Command dispatcher: pops a command, strobes the addressed target and returns read data
// as a message. Define MON_CMD_TIMEOUT_EN to add the handshake watchdog.
module mon_cmd_dispatcher
    import monitor_pkg::*;
#(
    parameter  int                 AGRP_W      = AGRP_W_DEF,
    parameter  int                 ADDR_W      = ADDR_W_DEF,
    parameter  int                 DATA_W      = DATA_W_DEF,
    parameter  int                 NUM_TGT     = 16,
    parameter  logic [NUM_TGT-1:0] HS_MASK     = '1,
    parameter  int                 TIMEOUT_CYC = 1024,
    localparam int                 CMD_W       = cmd_width(AGRP_W, ADDR_W, DATA_W)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CMD_W-1:0]          cmd,
    input  logic                      cmd_ready,
    output logic                      cmd_read_en,
    output logic [ADDR_W-1:0]         cmd_addr,
    output logic [DATA_W-1:0]         cmd_data,
    output logic [NUM_TGT-1:0]        tgt_read_en,
    output logic [NUM_TGT-1:0]        tgt_write_en,
    input  logic [NUM_TGT-1:0]        tgt_done,
    input  logic [NUM_TGT*DATA_W-1:0] tgt_read_data,
    output logic [CMD_W-1:0]          read_msg,
    output logic                      read_msg_valid,
    input  logic                      read_msg_ack,
    output logic                      cmd_err
);

    disp_state_t        state_q;
    logic [CMD_W-1:0]   cmd_q;
    logic [CMD_W-1:0]   msg_q;
    logic [NUM_TGT-1:0] strobe_q;
    logic               valid_q;
    logic               err_q;

    logic [AGRP_W-1:0]  in_grp;
    logic [AGRP_W-1:0]  grp_q;
    logic [NUM_TGT-1:0] in_sel;
    logic [NUM_TGT-1:0] strobe_out;
    logic [DATA_W-1:0]  rdata_sel;
    logic               in_mapped;
    logic               wr_q;
    logic               hs_sel;
    logic               done_sel;
    logic               exec_done;
    logic               wd_expired;

    assign in_grp = cmd[CMD_W-2 -: AGRP_W];

    // Group decode; groups beyond NUM_TGT decode to all zeros and are unmapped.
    for (genvar gi = 0; gi < NUM_TGT; gi++) begin : g_dec
        assign in_sel[gi] = (in_grp == AGRP_W'(gi));
    end
    assign in_mapped = |in_sel;

    assign wr_q     = cmd_q[CMD_W-1];
    assign grp_q    = cmd_q[CMD_W-2 -: AGRP_W];
    assign cmd_addr = cmd_q[DATA_W +: ADDR_W];
    assign cmd_data = cmd_q[DATA_W-1:0];

    // strobe_q is non-zero only in EXEC and then holds the selected target.
    assign hs_sel    = |(strobe_q & HS_MASK);
    assign done_sel  = |(strobe_q & tgt_done);
    assign exec_done = hs_sel ? done_sel : 1'b1;

    // A handshake target's strobe drops in the very cycle it reports done.
    assign strobe_out   = strobe_q & ~(tgt_done & HS_MASK);
    assign tgt_read_en  = wr_q ? '0 : strobe_out;
    assign tgt_write_en = wr_q ? strobe_out : '0;

    always_comb begin
        rdata_sel = '0;
        for (int t = 0; t < NUM_TGT; t++) begin
            if (strobe_q[t]) begin
                rdata_sel = rdata_sel | tgt_read_data[t*DATA_W +: DATA_W];
            end
        end
    end

    assign cmd_read_en    = rst_n && (state_q == ST_IDLE) && cmd_ready;
    assign read_msg       = msg_q;
    assign read_msg_valid = valid_q;
    assign cmd_err        = err_q;

`ifdef MON_CMD_TIMEOUT_EN
    logic wd_cnt_en;
    logic wd_clr;

    assign wd_cnt_en = (state_q == ST_EXEC) && hs_sel;
    assign wd_clr    = cmd_read_en && in_mapped;

    mon_cmd_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .cnt_en_i  (wd_cnt_en),
        .clr_i     (wd_clr),
        .expired_o (wd_expired)
    );
`else
    // No watchdog in this build: never expires, TIMEOUT_CYC has no effect.
    assign wd_expired = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cmd_q    <= '0;
            strobe_q <= '0;
            msg_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_ready) begin
                        cmd_q <= cmd;
                        if (in_mapped) begin
                            strobe_q <= in_sel;
                            state_q  <= ST_EXEC;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    if (exec_done || wd_expired) begin
                        strobe_q <= '0;
                        err_q    <= !exec_done;
                        if (wr_q) begin
                            state_q <= ST_IDLE;
                        end else begin
                            msg_q   <= {1'b1, grp_q, cmd_addr,
                                        exec_done ? rdata_sel : TIMEOUT_DATA[DATA_W-1:0]};
                            valid_q <= 1'b1;
                            state_q <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (read_msg_ack) begin
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
